// File: rtl/shift_add_mult_if.sv
// Handshake/operand bundle for the shift-and-add multiplier.
interface shift_add_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output a,
    output b,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output product,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH-bit add per cycle,
// 2*WIDTH-bit product after WIDTH compute cycles, start/busy/done handshake.
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clock,
  input logic            clear,
  shift_add_mult_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH:0]       sum;

  // Partial-product add; carry is kept as the top bit and shifted in at the MSB.
  always_comb begin
    sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  end

  // Control FSM and datapath registers; busy/done/product are all registered.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q  <= bus.a;
            acc_hi_q <= '0;
            acc_lo_q <= bus.b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_hi_q <= sum[WIDTH:1];
          acc_lo_q <= {sum[0], acc_lo_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            product_q <= {sum, acc_lo_q[WIDTH-1:1]};
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed cases plus a random sweep
// compared against plain a*b arithmetic, on WIDTH=8 and WIDTH=4 instances.
module tb_shift_add_mult;

  logic clock;
  logic clear;
  int   passed;
  int   total;

  shift_add_mult_if #(.WIDTH(8)) b8 ();
  shift_add_mult_if #(.WIDTH(4)) b4 ();

  shift_add_mult #(.WIDTH(8)) dut8 (.clock(clock), .clear(clear), .bus(b8.slave));
  shift_add_mult #(.WIDTH(4)) dut4 (.clock(clock), .clear(clear), .bus(b4.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One full operation on the 8-bit instance with operand scrambling after accept.
  task automatic mult8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int   lat;
    logic busy_ok;
    logic [63:0] expv;
    expv = 64'(x) * 64'(y);
    @(negedge clock);
    b8.start = 1'b1; b8.a = x; b8.b = y;
    @(posedge clock); #1;
    b8.start = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom);
    check({tag, " busy after accept"}, 64'(b8.busy), 64'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (!b8.done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      if (!b8.busy) busy_ok = 1'b0;
      b8.a = 8'($urandom); b8.b = 8'($urandom);
    end
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " product"}, 64'(b8.product), expv);
    check({tag, " busy held"}, 64'(busy_ok), 64'd1);
    @(posedge clock); #1;
    check({tag, " idle done"}, 64'(b8.done), 64'd0);
    check({tag, " idle busy"}, 64'(b8.busy), 64'd0);
    check({tag, " product held"}, 64'(b8.product), expv);
  endtask

  // Same operation on the 4-bit instance.
  task automatic mult4(input logic [3:0] x, input logic [3:0] y, input string tag);
    int lat;
    logic [63:0] expv;
    expv = 64'(x) * 64'(y);
    @(negedge clock);
    b4.start = 1'b1; b4.a = x; b4.b = y;
    @(posedge clock); #1;
    b4.start = 1'b0; b4.a = 4'($urandom); b4.b = 4'($urandom);
    lat = 0;
    while (!b4.done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      b4.a = 4'($urandom); b4.b = 4'($urandom);
    end
    check({tag, " latency4"}, 64'(lat), 64'd4);
    check({tag, " product4"}, 64'(b4.product), expv);
    @(posedge clock); #1;
    check({tag, " idle busy4"}, 64'(b4.busy), 64'd0);
  endtask

  initial begin
    int   dones;
    int   done_k [$];
    logic [63:0] done_p [$];
    logic held_ok;

    passed = 0;
    total  = 0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0;
    clear = 1'b1;
    #1;
    check("reset busy", 64'(b8.busy), 64'd0);
    check("reset done", 64'(b8.done), 64'd0);
    check("reset product", 64'(b8.product), 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b0;

    mult8(8'd13, 8'd11, "13x11");
    mult8(8'd255, 8'd255, "255x255");
    mult8(8'd0, 8'd200, "0x200");
    mult8(8'd1, 8'd255, "1x255");

    // start pulsed while busy must be ignored
    @(negedge clock);
    b8.start = 1'b1; b8.a = 8'd6; b8.b = 8'd7;
    @(posedge clock); #1;
    b8.start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (b8.done) begin
        dones++;
        check("busy-start product", 64'(b8.product), 64'd42);
      end
      b8.start = (k == 2);
      b8.a = (k == 2) ? 8'd9 : 8'($urandom);
      b8.b = (k == 2) ? 8'd9 : 8'($urandom);
    end
    check("busy-start single done", 64'(dones), 64'd1);
    check("busy-start no relaunch", 64'(b8.busy), 64'd0);

    // start held high: two ops 10 cycles apart
    @(negedge clock);
    b8.start = 1'b1; b8.a = 8'd3; b8.b = 8'd5;
    @(posedge clock); #1;
    b8.a = 8'd10; b8.b = 8'd10;
    held_ok = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clock); #1;
      if (k == 10) b8.start = 1'b0;
      if (b8.done) begin
        done_k.push_back(k);
        done_p.push_back(64'(b8.product));
      end
      if (k >= 9 && k <= 17 && b8.product !== 16'd15) held_ok = 1'b0;
    end
    check("b2b done count", 64'(done_k.size()), 64'd2);
    if (done_k.size() == 2) begin
      check("b2b first done", 64'(done_k[0]), 64'd8);
      check("b2b spacing", 64'(done_k[1] - done_k[0]), 64'd10);
      check("b2b first product", done_p[0], 64'd15);
      check("b2b second product", done_p[1], 64'd100);
    end
    check("b2b product held", 64'(held_ok), 64'd1);

    // asynchronous clear mid-RUN
    @(negedge clock);
    b8.start = 1'b1; b8.a = 8'd100; b8.b = 8'd100;
    @(posedge clock); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check("clear busy", 64'(b8.busy), 64'd0);
    check("clear done", 64'(b8.done), 64'd0);
    check("clear product", 64'(b8.product), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (b8.done) dones++;
    end
    check("clear no done", 64'(dones), 64'd0);
    mult8(8'd2, 8'd3, "after clear 2x3");

    mult4(4'd15, 4'd15, "w4 15x15");
    for (int i = 0; i < 50; i++) mult4(4'($urandom), 4'($urandom), "w4 rand");
    for (int i = 0; i < 1000; i++) mult8(8'($urandom), 8'($urandom), "rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
